door_lock_controller: RTL and testbench

//  Multi-door lock controller with auto-relock.
//  - N_DOORS independent channels; each has a fail-secure lock FSM.
//  - Unlock on request (req/ack). Relock after TIMEOUT consecutive cycles with
//    no motion, or immediately on a lock request.
//  - Sits between the door motion sensors / access logic and the lock actuators.

---
 rtl/door_lock_controller.sv | 129 ++++++++++++
 tb/tb_door_lock_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/door_lock_controller.sv
// Multi-door fail-secure lock controller with idle-timeout auto-relock and per-door req/ack grants.
// Optional sticky forced-entry alarm is built only when DOOR_ALARM_EN is defined.
module door_lock_controller #(
  parameter int N_DOORS  = 4,
  parameter int SENSOR_W = 1,
  parameter int TIMEOUT  = 1000
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_DOORS*SENSOR_W-1:0]   door_motion_sensor,
  input  logic [N_DOORS-1:0]            unlock_req,
  input  logic [N_DOORS-1:0]            lock_req,
  output logic [N_DOORS-1:0]            unlock_ack,
  output logic [N_DOORS-1:0]            lock_door,
  output logic [N_DOORS-1:0]            alarm,
  input  logic [N_DOORS-1:0]            alarm_clr
);

  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT - 1);

  // LOCKED encoded as 1 so the state flop drives the actuator directly.
  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  state_t             state_q [N_DOORS];
  state_t             state_d [N_DOORS];
  logic [CNT_W-1:0]   cnt_q   [N_DOORS];
  logic [CNT_W-1:0]   cnt_d   [N_DOORS];
  logic [N_DOORS-1:0] ack_q;
  logic [N_DOORS-1:0] ack_d;
  logic [N_DOORS-1:0] motion;

  always_comb begin
    for (int i = 0; i < N_DOORS; i++) begin
      motion[i] = |door_motion_sensor[i*SENSOR_W +: SENSOR_W];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_DOORS; i++) begin
        state_q[i] <= LOCKED;
        cnt_q[i]   <= '0;
      end
      ack_q <= '0;
    end else begin
      for (int i = 0; i < N_DOORS; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      ack_q <= ack_d;
    end
  end

  always_comb begin
    ack_d = '0;
    for (int i = 0; i < N_DOORS; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        LOCKED: begin
          if (unlock_req[i] && !lock_req[i]) begin
            state_d[i] = UNLOCKED;
            cnt_d[i]   = '0;
            ack_d[i]   = 1'b1;
          end
        end
        UNLOCKED: begin
          // Lock request outranks re-grant, motion and timeout.
          if (lock_req[i]) begin
            state_d[i] = LOCKED;
            cnt_d[i]   = '0;
          end else if (unlock_req[i]) begin
            cnt_d[i] = '0;
            ack_d[i] = 1'b1;
          end else if (motion[i]) begin
            cnt_d[i] = '0;
          end else if (cnt_q[i] == CNT_MAX) begin
            state_d[i] = LOCKED;
            cnt_d[i]   = '0;
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end
        default: begin
          state_d[i] = LOCKED;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < N_DOORS; i++) begin
      lock_door[i] = (state_q[i] == LOCKED);
    end
  end

  assign unlock_ack = ack_q;

`ifdef DOOR_ALARM_EN
  logic [N_DOORS-1:0] alarm_q;

  // Set beats clear when both happen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_q <= '0;
    end else begin
      for (int i = 0; i < N_DOORS; i++) begin
        if (state_q[i] == LOCKED && motion[i] && !unlock_req[i]) begin
          alarm_q[i] <= 1'b1;
        end else if (alarm_clr[i]) begin
          alarm_q[i] <= 1'b0;
        end
      end
    end
  end

  assign alarm = alarm_q;
`else
  logic unused_alarm_clr;
  assign unused_alarm_clr = ^alarm_clr;
  assign alarm = '0;
`endif

endmodule

// File: tb/tb_door_lock_controller.sv
// Directed bench for door_lock_controller with TIMEOUT=8; alarm checks follow DOOR_ALARM_EN.
module tb_door_lock_controller;

  logic       clk;
  logic       rst_n;
  logic [3:0] door_motion_sensor;
  logic [3:0] unlock_req;
  logic [3:0] lock_req;
  logic [3:0] unlock_ack;
  logic [3:0] lock_door;
  logic [3:0] alarm;
  logic [3:0] alarm_clr;

  int n_vec;
  int n_err;
  logic alarm_on;

  door_lock_controller #(
    .N_DOORS (4),
    .SENSOR_W(1),
    .TIMEOUT (8)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .door_motion_sensor(door_motion_sensor),
    .unlock_req        (unlock_req),
    .lock_req          (lock_req),
    .unlock_ack        (unlock_ack),
    .lock_door         (lock_door),
    .alarm             (alarm),
    .alarm_clr         (alarm_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
`ifdef DOOR_ALARM_EN
    alarm_on = 1'b1;
`else
    alarm_on = 1'b0;
`endif

    // Reset with random inputs
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      door_motion_sensor = 4'($urandom);
      unlock_req         = 4'($urandom);
      lock_req           = 4'($urandom);
      alarm_clr          = 4'($urandom);
      tick();
    end
    check("rst_lock", lock_door, 4'b1111);
    check("rst_ack", unlock_ack, 4'b0000);
    check("rst_alarm", alarm, 4'b0000);
    door_motion_sensor = '0;
    unlock_req = '0;
    lock_req   = '0;
    alarm_clr  = '0;
    #2 rst_n = 1'b1;
    tick();
    check("post_rst_lock", lock_door, 4'b1111);

    // Unlock door 0, then idle timeout after 8 cycles
    unlock_req = 4'b0001;
    tick();
    check("unl0_lock", lock_door, 4'b1110);
    check("unl0_ack", unlock_ack, 4'b0001);
    unlock_req = '0;
    for (int k = 1; k < 8; k++) begin
      tick();
      check("to0_hold", lock_door, 4'b1110);
      check("to0_noack", unlock_ack, 4'b0000);
    end
    tick();
    check("to0_relock", lock_door, 4'b1111);

    // Motion at the 5th idle edge restarts the count
    unlock_req = 4'b0001;
    tick();
    check("mv0_unl", lock_door, 4'b1110);
    unlock_req = '0;
    for (int k = 1; k < 5; k++) tick();
    door_motion_sensor = 4'b0001;
    tick();
    door_motion_sensor = '0;
    for (int k = 6; k < 13; k++) tick();
    check("mv0_extended", lock_door, 4'b1110);
    tick();
    check("mv0_relock", lock_door, 4'b1111);
    check("mv0_alarm", alarm, 4'b0000);

    // Priority on door 1
    unlock_req = 4'b0010;
    lock_req   = 4'b0010;
    tick();
    check("pri_both_lock", lock_door, 4'b1111);
    check("pri_both_ack", unlock_ack, 4'b0000);
    lock_req = '0;
    tick();
    check("pri_unl_lock", lock_door, 4'b1101);
    check("pri_unl_ack", unlock_ack, 4'b0010);
    tick();
    check("pri_regrant_ack", unlock_ack, 4'b0010);
    unlock_req = '0;
    door_motion_sensor = 4'b0010;
    lock_req = 4'b0010;
    tick();
    check("pri_lockmv_lock", lock_door, 4'b1111);
    check("pri_lockmv_ack", unlock_ack, 4'b0000);
    door_motion_sensor = '0;
    lock_req = '0;
    unlock_req = 4'b0010;
    tick();
    check("pri_reunl", lock_door, 4'b1101);
    lock_req = 4'b0010;
    tick();
    check("pri_lockwin_lock", lock_door, 4'b1111);
    check("pri_lockwin_ack", unlock_ack, 4'b0000);
    lock_req = '0;
    unlock_req = '0;
    tick();

    // Async reset while door 2 is unlocked
    unlock_req = 4'b0100;
    tick();
    check("ar_unl", lock_door, 4'b1011);
    check("ar_ack", unlock_ack, 4'b0100);
    unlock_req = '0;
    #2 rst_n = 1'b0;
    #1;
    check("ar_lock_now", lock_door, 4'b1111);
    check("ar_ack_now", unlock_ack, 4'b0000);
    #2 rst_n = 1'b1;
    tick();
    check("ar_after_lock", lock_door, 4'b1111);
    check("ar_after_ack", unlock_ack, 4'b0000);

    // Forced-entry alarm on door 3
    door_motion_sensor = 4'b1000;
    tick();
    check("al_set", alarm, alarm_on ? 4'b1000 : 4'b0000);
    door_motion_sensor = '0;
    tick();
    check("al_sticky", alarm, alarm_on ? 4'b1000 : 4'b0000);
    check("al_fsm_lock", lock_door, 4'b1111);
    alarm_clr = 4'b1000;
    tick();
    check("al_clr", alarm, 4'b0000);
    door_motion_sensor = 4'b1000;
    tick();
    check("al_set_beats_clr", alarm, alarm_on ? 4'b1000 : 4'b0000);
    door_motion_sensor = '0;
    tick();
    check("al_clr2", alarm, 4'b0000);
    alarm_clr = '0;
    door_motion_sensor = 4'b1000;
    unlock_req = 4'b1000;
    tick();
    check("al_auth_none", alarm, 4'b0000);
    check("al_auth_unl", lock_door, 4'b0111);
    check("al_auth_ack", unlock_ack, 4'b1000);
    door_motion_sensor = '0;
    unlock_req = '0;
    lock_req = 4'b1000;
    tick();
    check("al_final_lock", lock_door, 4'b1111);
    lock_req = '0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
